// File: rtl/smem_arbiter.sv
// Single-port screen memory arbiter: display reads own the port during active video,
// while queued CPU writes and the fill/clear engine share the blanking cycles.
module smem_arbiter #(
    parameter  int numChars = 4,
    parameter  int Dbits    = 11,
    parameter  int numCells = 1200,
    localparam int CW       = $clog2(numChars)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             activevideo,
    input  logic [Dbits-1:0] disp_addr,
    output logic [CW-1:0]    disp_charcode,
    input  logic             cpu_wr_req,
    input  logic [Dbits-1:0] cpu_wr_addr,
    input  logic [CW-1:0]    cpu_wr_data,
    output logic             cpu_wr_ready,
    input  logic             clr_start,
    input  logic [CW-1:0]    clr_char,
    output logic             clr_ready,
    output logic             clr_busy,
    output logic             clr_done,
    output logic [Dbits-1:0] mem_addr,
    output logic             mem_we,
    output logic [CW-1:0]    mem_wdata,
    input  logic [CW-1:0]    mem_rdata
);

    localparam int unsigned DEPTH = 4;
    localparam logic [Dbits-1:0] LAST_CELL = Dbits'(numCells - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [Dbits-1:0] fifo_addr_q [DEPTH];
    logic [CW-1:0]    fifo_data_q [DEPTH];
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [2:0]       count_q, count_d;
    logic [Dbits-1:0] fill_q, fill_d;
    logic [CW-1:0]    clr_char_q, clr_char_d;
    logic             clr_done_q, clr_done_d;

    logic fill_wr;
    logic pop;
    logic push;
    logic start;

    always_comb begin
        fill_wr = !activevideo && (state_q == CLEAR);
        pop     = !activevideo && (state_q == IDLE) && (count_q != 3'd0);
        push    = cpu_wr_req && (count_q != 3'd4);
        start   = clr_start && (state_q == IDLE) && (count_q == 3'd0);
    end

    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        clr_char_d = clr_char_q;
        clr_done_d = 1'b0;
        if (start) begin
            state_d    = CLEAR;
            fill_d     = '0;
            clr_char_d = clr_char;
        end else if (fill_wr) begin
            if (fill_q == LAST_CELL) begin
                state_d    = IDLE;
                fill_d     = '0;
                clr_done_d = 1'b1;
            end else begin
                fill_d = fill_q + 1'b1;
            end
        end

        rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fill_q     <= '0;
            clr_char_q <= '0;
            clr_done_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fill_q     <= fill_d;
            clr_char_q <= clr_char_d;
            clr_done_q <= clr_done_d;
            if (push) begin
                fifo_addr_q[wr_ptr_q] <= cpu_wr_addr;
                fifo_data_q[wr_ptr_q] <= cpu_wr_data;
            end
        end
    end

    // Fill has priority over the FIFO in blanking; pushes made during a fill drain afterwards.
    always_comb begin
        mem_addr  = disp_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (fill_wr) begin
            mem_addr  = fill_q;
            mem_wdata = clr_char_q;
            mem_we    = 1'b1;
        end else if (pop) begin
            mem_addr  = fifo_addr_q[rd_ptr_q];
            mem_wdata = fifo_data_q[rd_ptr_q];
            mem_we    = 1'b1;
        end
    end

    assign disp_charcode = mem_rdata;
    assign cpu_wr_ready  = (count_q != 3'd4);
    assign clr_ready     = (state_q == IDLE) && (count_q == 3'd0);
    assign clr_busy      = (state_q == CLEAR);
    assign clr_done      = clr_done_q;

endmodule

// File: doc/smem_arbiter.md
# smem_arbiter

Owns the single port of the 40x30 character screen memory and shares it between the VGA display driver (read every pixel clock during active video) and two writers: a CPU write queue and a hardware fill/clear engine. The display always wins while `activevideo` is high. Writes are buffered in a 4-entry FIFO and drained only during blanking. The clear engine walks every cell during blanking. The block sits between the CPU memory-mapped write path, the display driver's `smem_addr`/`charcode` pins and the screen RAM.

## Interface
- `numChars`, 4: glyphs in bitmap memory. Character width `CW = $clog2(numChars)`.
- `Dbits`, 11: screen memory address width.
- `numCells`, 1200: cells in screen memory (40 cols x 30 rows).
- `clk` input 1: single clock (VGA pixel clock domain).
- `reset_n` input 1: asynchronous, active-low reset.
- `activevideo` input 1: high while the display scans visible pixels.
- `disp_addr` input Dbits: cell address requested by the display driver.
- `disp_charcode` output CW: character at `disp_addr`, equal to `mem_rdata`.
- `cpu_wr_req` input 1: CPU write request.
- `cpu_wr_addr` input Dbits: target cell.
- `cpu_wr_data` input CW: character code.
- `cpu_wr_ready` output 1: FIFO can accept. A transfer occurs when `cpu_wr_req` and `cpu_wr_ready` are both high on a rising edge.
- `clr_start` input 1: start a fill of all cells.
- `clr_char` input CW: fill character. Sampled when a start is accepted.
- `clr_ready` output 1: a start is accepted this cycle if `clr_start` is high.
- `clr_busy` output 1: fill in progress.
- `clr_done` output 1: one-cycle pulse after the last cell is written.
- `mem_addr` output Dbits: screen memory address.
- `mem_we` output 1: screen memory write enable, sampled on `clk`.
- `mem_wdata` output CW: screen memory write data.
- `mem_rdata` input CW: combinational read data for `mem_addr`.

## Operation
- **States:** IDLE and CLEAR. There is also a 4-entry write FIFO with read/write pointers and a 3-bit count, and an `Dbits`-wide fill counter.
- **Port mux, active video** (`activevideo`=1):
  - `mem_addr = disp_addr`, `mem_we = 0`.
  - No FIFO pop and no fill-counter advance.
- **Port mux, blanking, state CLEAR:**
  - `mem_addr` = fill counter, `mem_wdata` = latched `clr_char`, `mem_we = 1`.
  - Counter increments each such cycle.
- **Port mux, blanking, state IDLE, FIFO non-empty:**
  - `mem_addr`/`mem_wdata` = FIFO head, `mem_we = 1`.
  - Head pops at the edge.
- **Port mux, otherwise:** `mem_addr = disp_addr`, `mem_we = 0`.
- **Outputs:**
  - `disp_charcode = mem_rdata` at all times. Its value is only meaningful during active video.
  - `cpu_wr_ready = (count != 4)`. It does not depend on a same-cycle pop, so a full FIFO refuses a push even while popping.
  - A simultaneous push and pop leaves `count` unchanged. Order is strictly FIFO.
  - `clr_ready = IDLE && count == 0`. `clr_start` while `clr_ready`=0 is ignored, not remembered.
- **Fill:**
  - On an accepted start: go to CLEAR, zero the counter, latch `clr_char`.
  - When the write to address `numCells-1` occurs, return to IDLE and assert `clr_done` the next cycle.
  - CPU pushes are accepted during CLEAR and queued. They drain after the fill, so they are never overwritten by it.
- **Addresses:**
  - Addresses >= `numCells` from the CPU are written through unchanged; the memory ignores them.
  - The fill counter never exceeds `numCells-1`.

## Timing
- **Reset values:** state IDLE, FIFO empty, counter 0.
  - `mem_we=0`, `mem_addr=disp_addr`.
  - `cpu_wr_ready=1`, `clr_ready=1`, `clr_busy=0`, `clr_done=0`.
- **Reset mid-fill:** returns to IDLE immediately. No `clr_done`. Partially filled memory is left as is.
- **Reset with queued writes:** queued writes are discarded.
- **Write latency:** a push accepted at edge N is written to memory at the earliest at edge N+1, if `activevideo`=0 in cycle N+1. Otherwise it is written in the first blanking cycle after that.
- **Fill duration:** exactly `numCells` blanking cycles. Active-video cycles stall it without losing position.
- **Status outputs:**
  - `clr_busy` is high from the cycle after acceptance through the cycle of the final write.
  - `clr_ready` goes high when `clr_done` pulses, provided the FIFO is empty.
- **Output decoding:** all outputs are combinational from registered state plus `activevideo`, `disp_addr`, `mem_rdata`. There are no combinational paths from `cpu_wr_req` or `clr_start`.

## Test plan
- **Reset:** assert `reset_n`=0 mid-simulation -> all outputs at reset values. `mem_addr` tracks `disp_addr`=37 while `activevideo`=1.
- **Blanking write:** with `activevideo`=0, push (addr 41, data 2) -> next cycle `mem_we`=1, `mem_addr`=41, `mem_wdata`=2. Read back `disp_charcode`=2 during active video at `disp_addr`=41.
- **Deferred write and backpressure:** with `activevideo`=1, push 5 writes back-to-back -> first 4 accepted, `cpu_wr_ready`=0 on the 5th, `mem_we` stays 0. Drop `activevideo` -> 4 writes issued in push order on 4 consecutive cycles, then `cpu_wr_ready`=1.
- **Fill:** with the FIFO empty, `clr_start` with `clr_char`=3 and `activevideo` toggling -> exactly 1200 writes of 3 to addresses 0..1199, each only while `activevideo`=0. Then one `clr_done` pulse; `clr_busy` falls.
- **Start refused:** `clr_start` with one queued write -> ignored, `clr_busy` stays 0.
- **Pushes during fill:** push (addr 0, data 1) during a fill -> written after cell 1199, so the final memory state has cell 0 = 1.
- **Reset mid-fill:** assert `reset_n` after 600 fill writes -> IDLE, counter 0, no `clr_done`, and the next `clr_start` accepted.
